serial_adder: RTL

- Bit-serial WIDTH-bit adder built around the existing one-bit full adder (onebit_fa, dataflow).
- Adds operands LSB-first, one bit per clock, and holds the carry in a flip-flop between bits.
- Sits directly upstream of onebit_fa: it sequences operand bits and carry into the adder, then collects s/c back into a result shift register.
- A start/busy/done handshake lets a controller launch an addition and read the registered result.

---
 rtl/serial_adder.sv | 119 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: streams operands LSB-first through a one-bit full adder,
// holding the carry in a flop and publishing {cout,sum} once all bits are done.

module onebit_fa (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);
  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_c;

  onebit_fa u_fa (
    .x(a_q[0]),
    .y(b_q[0]),
    .z(carry_q),
    .s(fa_s),
    .c(fa_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        acc_d   = {fa_s, acc_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = {fa_s, acc_q[WIDTH-1:1]};
          cout_d  = fa_c;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
